data_mem_lsu: RTL and testbench
===============================

DATA_MEM_LSU -- requirements
Module: data_mem_lsu

Interface
REQ-001 Parameter STALL_TIMEOUT, default 64, meaning max WAIT cycles before a timeout error.
REQ-002 clk  in  1  single system clock, all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req_valid  in  1  pipeline presents a load/store.
REQ-005 req_ready  out  1  block accepts a request this cycle.
REQ-006 req_write  in  1  1 = store, 0 = load.
REQ-007 req_funct3  in  3  RV32I load/store funct3.
REQ-008 req_addr  in  32  byte address.
REQ-009 req_wdata  in  32  store data, right-aligned.
REQ-010 resp_valid  out  1  one-cycle completion pulse.
REQ-011 resp_rdata  out  32  load result; 0 for stores and errors.
REQ-012 resp_err  out  2  00 ok, 01 misaligned, 10 illegal funct3, 11 timeout.
REQ-013 mem_addr, mem_write_data  out  32 each  to data_mem addr/write_data.
REQ-014 mem_memread, mem_memwrite  out  1 each  to data_mem memread/memwrite.
REQ-015 mem_sign_mask  out  4  to data_mem sign_mask.
REQ-016 mem_read_data  in  32  from data_mem read_data.
REQ-017 mem_clk_stall  in  1  from data_mem clk_stall; high while access in progress.

Function
REQ-018 States IDLE, ISSUE, SETTLE, WAIT, RESP; only IDLE asserts req_ready.
REQ-019 Handshake req_valid&&req_ready in cycle N latches addr, wdata, write, decoded mask; next state ISSUE (legal) or RESP with error (illegal/misaligned).
REQ-020 Mask decode: load 000->1001, 001->1011, 010->0111, 100->0001, 101->0011; store 000->0001, 001->0011, 010->0111; all other funct3/direction combinations illegal (err 10).
REQ-021 Misaligned: halfword with addr[0]=1, word with addr[1:0]!=00 -> err 01; illegal funct3 takes priority over misalignment.
REQ-022 Error requests produce no memread/memwrite pulse; resp_valid in cycle N+1.
REQ-023 ISSUE (cycle N+1): exactly one of mem_memread/mem_memwrite high for that single cycle.
REQ-024 SETTLE (N+2): one cycle, mem_clk_stall ignored; then WAIT.
REQ-025 WAIT: stay while mem_clk_stall=1; on first cycle mem_clk_stall=0, capture mem_read_data (loads) and go RESP.
REQ-026 WAIT counter increments per WAIT cycle; reaching STALL_TIMEOUT -> RESP with err 11, resp_rdata 0.
REQ-027 mem_addr, mem_write_data, mem_sign_mask registered, held stable from ISSUE through end of WAIT, zero in IDLE.
REQ-028 RESP: resp_valid=1 one cycle with resp_rdata/resp_err; next state IDLE; minimum legal-access latency N to resp_valid = 4 cycles.
REQ-029 resp_rdata passed through unmodified; sign/zero extension done by data_mem.
REQ-030 req_valid outside IDLE ignored; no queueing.

Reset
REQ-031 reset=1 at a clock edge forces IDLE, clears counter, and drives all outputs 0 except req_ready (0 during reset, 1 in first post-reset IDLE cycle).
REQ-032 Reset mid-access abandons it: no resp_valid, no reissue.

Structure
REQ-033 Package data_mem_lsu_pkg holds state encoding, the five load/three store mask constants, and resp_err codes.
REQ-034 Combinational sub-module lsu_size_decode (funct3, write, addr[1:0] -> mask, illegal, misaligned) is the single decode point.

Verification
REQ-035 SB addr 0x400 wdata 0xAAA, stall 5 cycles -> mask 0001, one memwrite pulse, resp_valid err 00 rdata 0.
REQ-036 LB addr 0x400, mem_read_data 0xFFFFFFAA after stall -> mask 1001, one memread pulse, rdata 0xFFFFFFAA.
REQ-037 LHU addr 0x101 -> resp_err 01 in N+1, no memread; funct3 011 load -> err 10.
REQ-038 LW addr 0x40, stall never drops, STALL_TIMEOUT=8 -> resp_valid err 11 after 8 WAIT cycles.
REQ-039 reset asserted in WAIT of SW addr 0x40 -> IDLE next cycle, no resp_valid, all mem_* zero.
REQ-040 stall 0 throughout (zero-wait) LW -> resp_valid exactly 4 cycles after handshake.

Source files
------------

// File: rtl/data_mem_lsu_pkg.sv
// rtl/data_mem_lsu_pkg.sv - shared state encoding, size masks and response codes for the data memory LSU
package data_mem_lsu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_SETTLE,
        ST_WAIT,
        ST_RESP
    } lsu_state_t;

    // bit3 = sign-extend, bits[2:0] = byte/half/word width select for data_mem
    localparam logic [3:0] MASK_LB  = 4'b1001;
    localparam logic [3:0] MASK_LH  = 4'b1011;
    localparam logic [3:0] MASK_LW  = 4'b0111;
    localparam logic [3:0] MASK_LBU = 4'b0001;
    localparam logic [3:0] MASK_LHU = 4'b0011;

    localparam logic [3:0] MASK_SB  = 4'b0001;
    localparam logic [3:0] MASK_SH  = 4'b0011;
    localparam logic [3:0] MASK_SW  = 4'b0111;

    localparam logic [1:0] ERR_OK         = 2'b00;
    localparam logic [1:0] ERR_MISALIGNED = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT    = 2'b11;

endpackage

// File: rtl/lsu_size_decode.sv
// rtl/lsu_size_decode.sv - funct3/direction/address decode into data_mem mask and error flags
module lsu_size_decode
    import data_mem_lsu_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       write,
    input  logic [1:0] addr_lo,
    output logic [3:0] mask,
    output logic       illegal,
    output logic       misaligned
);

    // misaligned is reported raw; the caller gives illegal priority
    always_comb begin
        mask       = 4'b0000;
        illegal    = 1'b0;
        misaligned = 1'b0;
        if (write) begin
            case (funct3)
                3'b000:  mask = MASK_SB;
                3'b001:  begin mask = MASK_SH; misaligned = addr_lo[0]; end
                3'b010:  begin mask = MASK_SW; misaligned = |addr_lo;   end
                default: illegal = 1'b1;
            endcase
        end else begin
            case (funct3)
                3'b000:  mask = MASK_LB;
                3'b001:  begin mask = MASK_LH;  misaligned = addr_lo[0]; end
                3'b010:  begin mask = MASK_LW;  misaligned = |addr_lo;   end
                3'b100:  mask = MASK_LBU;
                3'b101:  begin mask = MASK_LHU; misaligned = addr_lo[0]; end
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/data_mem_lsu.sv
// rtl/data_mem_lsu.sv - single-outstanding load/store unit sequencing accesses to data_mem
module data_mem_lsu
    import data_mem_lsu_pkg::*;
#(
    parameter int STALL_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_memread,
    output logic        mem_memwrite,
    output logic [3:0]  mem_sign_mask,
    input  logic [31:0] mem_read_data,
    input  logic        mem_clk_stall
);

    localparam int CNT_W = $clog2(STALL_TIMEOUT + 1);

    lsu_state_t       state;
    logic [CNT_W-1:0] wait_cnt;
    logic             is_write;
    logic [3:0]       dec_mask;
    logic             dec_illegal;
    logic             dec_misaligned;

    lsu_size_decode u_size_decode (
        .funct3     (req_funct3),
        .write      (req_write),
        .addr_lo    (req_addr[1:0]),
        .mask       (dec_mask),
        .illegal    (dec_illegal),
        .misaligned (dec_misaligned)
    );

    assign req_ready = (state == ST_IDLE) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            wait_cnt       <= '0;
            is_write       <= 1'b0;
            resp_valid     <= 1'b0;
            resp_rdata     <= '0;
            resp_err       <= ERR_OK;
            mem_addr       <= '0;
            mem_write_data <= '0;
            mem_memread    <= 1'b0;
            mem_memwrite   <= 1'b0;
            mem_sign_mask  <= '0;
        end else begin
            resp_valid   <= 1'b0;
            mem_memread  <= 1'b0;
            mem_memwrite <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        is_write <= req_write;
                        if (dec_illegal || dec_misaligned) begin
                            resp_valid <= 1'b1;
                            resp_rdata <= '0;
                            resp_err   <= dec_illegal ? ERR_ILLEGAL : ERR_MISALIGNED;
                            state      <= ST_RESP;
                        end else begin
                            mem_addr       <= req_addr;
                            mem_write_data <= req_wdata;
                            mem_sign_mask  <= dec_mask;
                            mem_memread    <= !req_write;
                            mem_memwrite   <= req_write;
                            state          <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: state <= ST_SETTLE;
                ST_SETTLE: begin
                    // data_mem may not have raised clk_stall yet, so it is not looked at here
                    wait_cnt <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!mem_clk_stall || (wait_cnt == CNT_W'(STALL_TIMEOUT - 1))) begin
                        resp_valid     <= 1'b1;
                        resp_err       <= mem_clk_stall ? ERR_TIMEOUT : ERR_OK;
                        resp_rdata     <= (mem_clk_stall || is_write) ? 32'd0 : mem_read_data;
                        mem_addr       <= '0;
                        mem_write_data <= '0;
                        mem_sign_mask  <= '0;
                        state          <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    resp_rdata <= '0;
                    resp_err   <= ERR_OK;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_lsu.sv
// tb/tb_data_mem_lsu.sv - randomized self-checking bench for data_mem_lsu against a transaction-level model
module tb_data_mem_lsu;

    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_memread;
    logic        mem_memwrite;
    logic [3:0]  mem_sign_mask;
    logic [31:0] mem_read_data;
    logic        mem_clk_stall;

    int checks   = 0;
    int failures = 0;

    data_mem_lsu #(.STALL_TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_memread    (mem_memread),
        .mem_memwrite   (mem_memwrite),
        .mem_sign_mask  (mem_sign_mask),
        .mem_read_data  (mem_read_data),
        .mem_clk_stall  (mem_clk_stall)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", tag, act, exp);
        end
    endtask

    function automatic int unsigned ref_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit ref_legal(input bit wr, input logic [2:0] f3);
        if (f3[1:0] == 2'b11) return 1'b0;
        if (wr) return f3[2] == 1'b0;
        return f3 != 3'b110;
    endfunction

    function automatic logic [3:0] ref_mask(input bit wr, input logic [2:0] f3);
        logic [3:0] m;
        m[2:0] = 3'((1 << (f3[1:0] + 1)) - 1);
        m[3]   = !wr && !f3[2] && (f3[1:0] != 2'b10);
        return m;
    endfunction

    task automatic drive_idle_inputs();
        req_valid     = 1'b0;
        req_write     = 1'b0;
        req_funct3    = 3'b000;
        req_addr      = 32'd0;
        req_wdata     = 32'd0;
        mem_clk_stall = 1'b0;
        mem_read_data = 32'd0;
    endtask

    task automatic check_all_zero(input string name);
        check_eq({name, ".resp_valid"}, 32'(resp_valid), 32'd0);
        check_eq({name, ".mem_rw"}, 32'({mem_memread, mem_memwrite}), 32'd0);
        check_eq({name, ".mem_addr"}, mem_addr, 32'd0);
        check_eq({name, ".mem_wdata"}, mem_write_data, 32'd0);
        check_eq({name, ".mem_mask"}, 32'(mem_sign_mask), 32'd0);
        check_eq({name, ".resp_rdata"}, resp_rdata, 32'd0);
        check_eq({name, ".resp_err"}, 32'(resp_err), 32'd0);
    endtask

    // The memory holds clk_stall high for 'stall' cycles past SETTLE, then returns rd_val.
    task automatic run_access(input string name, input bit wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input int stall, input logic [31:0] rd_val);
        bit          legal = ref_legal(wr, f3);
        bit          mis   = legal && ((addr % ref_size(f3)) != 0);
        bit          ok    = legal && !mis;
        int          exp_lat;
        logic [1:0]  exp_err;
        logic [31:0] exp_rdata;
        int          resp_cyc = -1;
        int          n_rd = 0;
        int          n_wr = 0;
        int          hold_bad = 0;
        logic [1:0]  got_err = 2'b00;
        logic [31:0] got_rdata = 32'd0;
        logic [3:0]  got_mask = 4'd0;
        logic [31:0] got_addr = 32'd0;
        logic [31:0] got_wdata = 32'd0;

        if (!legal)              begin exp_err = 2'b10; exp_lat = 1; end
        else if (mis)            begin exp_err = 2'b01; exp_lat = 1; end
        else if (stall < TIMEOUT) begin exp_err = 2'b00; exp_lat = 4 + stall; end
        else                     begin exp_err = 2'b11; exp_lat = 3 + TIMEOUT; end
        exp_rdata = (exp_err == 2'b00 && !wr) ? rd_val : 32'd0;

        @(negedge clk);
        check_eq({name, ".ready"}, 32'(req_ready), 32'd1);
        req_valid     = 1'b1;
        req_write     = wr;
        req_funct3    = f3;
        req_addr      = addr;
        req_wdata     = wdata;
        mem_clk_stall = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (mem_memread)  n_rd++;
            if (mem_memwrite) n_wr++;
            if (k == 1) begin
                got_mask  = mem_sign_mask;
                got_addr  = mem_addr;
                got_wdata = mem_write_data;
            end else if (k < exp_lat && (mem_sign_mask !== got_mask || mem_addr !== got_addr
                                         || mem_write_data !== got_wdata)) begin
                hold_bad++;
            end
            if (resp_valid && resp_cyc < 0) begin
                resp_cyc  = k;
                got_err   = resp_err;
                got_rdata = resp_rdata;
            end else if (resp_valid) begin
                resp_cyc = 99;
            end
            if (resp_cyc > 0 && k == resp_cyc + 1) begin
                check_eq({name, ".idle_ready"}, 32'(req_ready), 32'd1);
                check_eq({name, ".idle_addr"}, mem_addr, 32'd0);
                check_eq({name, ".idle_mask"}, 32'(mem_sign_mask), 32'd0);
                break;
            end
            // junk requests while busy must be ignored
            req_valid     = (resp_cyc < 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            req_write     = 1'($urandom);
            req_funct3    = 3'($urandom);
            req_addr      = $urandom;
            req_wdata     = $urandom;
            mem_clk_stall = (k <= 2 + stall);
            mem_read_data = (k == 3 + stall) ? rd_val : $urandom;
        end
        req_valid = 1'b0;
        check_eq({name, ".latency"}, 32'(resp_cyc), 32'(exp_lat));
        check_eq({name, ".err"}, 32'(got_err), 32'(exp_err));
        check_eq({name, ".rdata"}, got_rdata, exp_rdata);
        check_eq({name, ".memread_pulses"}, 32'(n_rd), 32'(ok && !wr));
        check_eq({name, ".memwrite_pulses"}, 32'(n_wr), 32'(ok && wr));
        check_eq({name, ".mask"}, 32'(got_mask), ok ? 32'(ref_mask(wr, f3)) : 32'd0);
        check_eq({name, ".addr"}, got_addr, ok ? addr : 32'd0);
        check_eq({name, ".wdata"}, got_wdata, ok ? wdata : 32'd0);
        check_eq({name, ".hold_stable"}, 32'(hold_bad), 32'd0);
    endtask

    task automatic run_reset_in_wait();
        int stray = 0;
        @(negedge clk);
        req_valid     = 1'b1;
        req_write     = 1'b1;
        req_funct3    = 3'b010;
        req_addr      = 32'h40;
        req_wdata     = 32'h5A5A_0F0F;
        mem_clk_stall = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 5) begin
                check_eq("rst_wait.ready_in_reset", 32'(req_ready), 32'd0);
                check_all_zero("rst_wait");
                reset = 1'b0;
            end else if (k == 6) begin
                check_eq("rst_wait.ready_after", 32'(req_ready), 32'd1);
            end else if (k > 6 && (resp_valid || mem_memread || mem_memwrite)) begin
                stray++;
            end
            req_valid     = 1'b0;
            mem_clk_stall = 1'b1;
            if (k == 4) reset = 1'b1;
        end
        check_eq("rst_wait.no_resp_or_reissue", 32'(stray), 32'd0);
        mem_clk_stall = 1'b0;
    endtask

    initial begin
        logic [31:0] addr;
        bit          wr;
        logic [2:0]  f3;
        reset = 1'b1;
        drive_idle_inputs();
        repeat (3) @(negedge clk);
        check_eq("reset.ready", 32'(req_ready), 32'd0);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);
        check_eq("post_reset.ready", 32'(req_ready), 32'd1);

        run_access("sb_0x400", 1'b1, 3'b000, 32'h400, 32'hAAA, 5, 32'h0);
        run_access("lb_0x400", 1'b0, 3'b000, 32'h400, 32'h0, 3, 32'hFFFF_FFAA);
        run_access("lhu_mis", 1'b0, 3'b101, 32'h101, 32'h0, 0, 32'h0);
        run_access("load_f3_011", 1'b0, 3'b011, 32'h100, 32'h0, 0, 32'h0);
        run_access("lw_timeout", 1'b0, 3'b010, 32'h40, 32'h0, 100, 32'h1234);
        run_reset_in_wait();
        run_access("lw_zero_wait", 1'b0, 3'b010, 32'h80, 32'h0, 0, 32'hCAFE_F00D);
        run_access("lw_stall_7", 1'b0, 3'b010, 32'h84, 32'h0, TIMEOUT - 1, 32'h1357_9BDF);
        run_access("lw_stall_8", 1'b0, 3'b010, 32'h88, 32'h0, TIMEOUT, 32'h2468_ACE0);
        run_access("sw_mis", 1'b1, 3'b010, 32'h42, 32'h1111, 0, 32'h0);
        run_access("sh_mis", 1'b1, 3'b001, 32'h43, 32'h2222, 0, 32'h0);
        run_access("store_f3_100", 1'b1, 3'b100, 32'h43, 32'h3333, 0, 32'h0);
        run_access("lh_ok", 1'b0, 3'b001, 32'h102, 32'h0, 2, 32'hFFFF_8001);
        run_access("sh_ok", 1'b1, 3'b001, 32'h206, 32'hBEEF, 1, 32'h0);
        run_access("lbu_ok", 1'b0, 3'b100, 32'h303, 32'h0, 0, 32'h0000_00F0);

        for (int i = 0; i < 40; i++) begin
            wr   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            addr = $urandom;
            if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
            run_access($sformatf("rand%0d", i), wr, f3, addr, $urandom,
                       int'($urandom_range(0, 10)), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
